imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Hardware program loader: the write side of instruction-memory initialisation, replacing simulation-only file loading.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words.
- Writes the words sequentially into the IFU instruction memory from word address 0.
- Holds the MIPS core in reset until a load completes with a good checksum.

Parameters:
ADDR_W, 10, instruction-memory word-address width; depth = 2**ADDR_W words.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins a load; honoured only when not busy
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader accepts a byte this cycle
im_we  out  1  instruction-memory write enable, one-cycle pulse per word
im_addr  out  ADDR_W  instruction-memory word address
im_wdata  out  32  instruction word
cpu_rst  out  1  active-high reset to the mips core
busy  out  1  load in progress
done  out  1  level; last load succeeded
err  out  1  level; last load failed

Behaviour:
- Reset (rst=0, asynchronous): state IDLE.
  - Outputs: in_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, cpu_rst=1.
  - All counters and the checksum clear.
- Byte handshake: a transfer occurs on a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian, 16 bit), then 4*N data bytes, then CHK = XOR of all data bytes.
- States: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR.
- in_ready=1 exactly in LEN_HI, LEN_LO, DATA and CHK. busy=1 in the same states.
- IDLE/DONE/ERR + start -> LEN_HI:
  - done=0, err=0, cpu_rst=1.
  - Word index, byte index and checksum clear.
- start while busy is ignored.
- LEN_HI: on transfer, store the high byte -> LEN_LO.
- LEN_LO: on transfer, form N.
  - N==0 or N>2**ADDR_W -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Byte index 0..3. Byte 0 goes to bits 31:24, byte 3 to bits 7:0 (same order as the hex image).
  - Each data byte is XORed into the running checksum.
  - On the transfer of byte 3:
    - In the next cycle im_we=1, im_addr=word index, im_wdata=assembled word, for exactly one cycle.
    - The word index then increments.
  - After the write of word N-1 is issued -> CHK.
  - No back-pressure: the loader stays ready while the write pulse is out.
- im_addr/im_wdata hold their last values when im_we=0.
- CHK: on transfer:
  - byte == checksum -> DONE.
  - Otherwise -> ERR.
- DONE: done=1, cpu_rst=0, asserted in the cycle after the CHK transfer. Holds until the next start or rst.
- ERR: err=1, cpu_rst=1. Holds until the next start or rst. Words already written are not erased.
- Gaps in in_valid stall the FSM without affecting state or checksum.
- Word index wrap is impossible because N is bounded by the depth check.
- rst mid-load: immediate return to reset values. Memory contents are left as partially written. A later start performs a clean full reload.

Decomposition:
- Shared package:
  - State encoding constants.
  - LEN_BYTES=2.
  - BYTES_PER_WORD=4.
  - Checksum seed 8'h00.
- Sub-module byte_packer:
  - Shifts four bytes into a 32-bit word.
  - Owns the byte index.
  - Emits a one-cycle word_valid.
  - Has a synchronous clear used on start.
- imem_loader owns the FSM, length check, word index, checksum and the memory/CPU-reset outputs.

Test Plan:
- Good load, N=2:
  - Stimulus: start; bytes 00 02 20 08 00 05 20 09 00 0A 0E, valid every cycle.
  - Response: im_we at addr 0 with 0x20080005, then at addr 1 with 0x2009000A; done=1, err=0, cpu_rst=0 one cycle after the 0E transfer.
- Bad checksum: same frame ending 0F -> both words written; err=1, done=0, cpu_rst stays 1.
- Length errors:
  - N=0 (00 00) -> ERR right after LEN_LO; no im_we; in_ready=0 afterwards.
  - With ADDR_W=4, N=17 (00 11) -> ERR.
- Stalls:
  - Stimulus: test 1 frame with in_valid high only every third cycle, and a start pulse injected during DATA.
  - Response: identical writes and done; the start has no effect.
- Async reset:
  - Stimulus: drop rst for 2 ns mid-DATA after word 0.
  - Response: all outputs return to reset values without waiting for clk; a subsequent start plus the full good frame reaches DONE with the correct writes.
- Back-to-back loads: after DONE, start and load N=1 (00 01 24 0A 00 01 2F) -> done clears on start; one write at addr 0 with 0x240A0001; done=1 again.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
package imem_loader_pkg;

  // Loader FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Frame header carries a big-endian 16-bit word count
  localparam int LEN_BYTES      = 2;
  // Instruction words are assembled from four big-endian bytes
  localparam int BYTES_PER_WORD = 4;
  // Running XOR checksum starts from this value
  localparam logic [7:0] CHK_SEED = 8'h00;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Shifts big-endian bytes into 32-bit words; first byte lands in bits 31:24.
// word holds its value between completions so the memory data bus stays stable.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        byte_last,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam int SH_W  = 8 * (BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx;
  logic [SH_W-1:0]  shift;

  // Current byte completes a word
  assign byte_last = (idx == IDX_W'(BYTES_PER_WORD - 1));

  // Byte index, partial-word shifter and completed-word register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx        <= '0;
      shift      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        idx   <= '0;
        shift <= '0;
      end else if (byte_en) begin
        if (byte_last) begin
          word       <= {shift, byte_in};
          word_valid <= 1'b1;
          idx        <= '0;
        end else begin
          shift <= {shift[SH_W-9:0], byte_in};
          idx   <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length/data/checksum byte frame, writes words into
// instruction memory from address 0 and releases the core reset on success.
// ADDR_W is limited to 16 since the frame length field is 16 bits wide.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int LEN_W = 8 * LEN_BYTES;
  localparam logic [LEN_W:0] DEPTH = (LEN_W+1)'(2 ** ADDR_W);

  state_t            state;
  logic [7:0]        len_hi;
  logic [7:0]        csum;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;

  logic              xfer;
  logic              go;
  logic              data_xfer;
  logic              byte_last;
  logic [LEN_W-1:0]  len_n;
  logic              len_bad;

  assign xfer      = in_valid & in_ready;
  assign go        = start & ~busy;
  assign data_xfer = xfer && (state == ST_DATA);
  assign len_n     = {len_hi, in_data};
  assign len_bad   = (len_n == '0) || ({1'b0, len_n} > DEPTH);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (go),
    .byte_en    (data_xfer),
    .byte_in    (in_data),
    .byte_last  (byte_last),
    .word_valid (im_we),
    .word       (im_wdata)
  );

  // Loader FSM with registered handshake, status and address outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
      len_hi   <= '0;
      csum     <= CHK_SEED;
      word_idx <= '0;
      last_idx <= '0;
      im_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LEN_HI;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_rst  <= 1'b1;
            word_idx <= '0;
            csum     <= CHK_SEED;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_hi <= in_data;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            if (len_bad) begin
              state    <= ST_ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              err      <= 1'b1;
            end else begin
              // N <= depth, so N-1 always fits the word address
              last_idx <= ADDR_W'(len_n - 1'b1);
              state    <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            csum <= csum ^ in_data;
            if (byte_last) begin
              // Packer raises im_we next cycle; address is latched alongside
              im_addr  <= word_idx;
              word_idx <= word_idx + 1'b1;
              if (word_idx == last_idx) state <= ST_CHK;
            end
          end
        end
        ST_CHK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_data == csum) begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (ADDR_W=4, depth 16 words).
module tb_imem_loader;

  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  int n_vec = 0;
  int n_err = 0;

  // Write log captured mid-cycle
  int          wr_n = 0;
  logic [31:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int          base;

  logic [7:0] good_frm [0:10];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write pulse
  always @(negedge clk) begin
    if (im_we && wr_n < 64) begin
      wr_addr[wr_n] <= 32'(im_addr);
      wr_data[wr_n] <= im_wdata;
      wr_n          <= wr_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Good N=2 frame with selectable checksum byte; optional 2-cycle gaps
  // before each byte and a start pulse injected in the gap before byte inj
  task automatic load_good(input logic [7:0] chk_byte, input bit stall, input int inj);
    for (int i = 0; i < 11; i++) begin
      if (stall) begin
        in_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          if (i == inj && g == 0) start = 1'b1;
          tick();
          start = 1'b0;
        end
      end
      send(i == 10 ? chk_byte : good_frm[i]);
    end
  endtask

  task automatic chk_two_writes(input string tag);
    chk({tag, " nwr"}, 32'(wr_n - base), 32'd2);
    chk({tag, " a0"},  wr_addr[base],     32'd0);
    chk({tag, " d0"},  wr_data[base],     32'h2008_0005);
    chk({tag, " a1"},  wr_addr[base+1],   32'd1);
    chk({tag, " d1"},  wr_data[base+1],   32'h2009_000A);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, " im_we"},    32'(im_we),    32'd0);
    chk({tag, " im_addr"},  32'(im_addr),  32'd0);
    chk({tag, " im_wdata"}, im_wdata,      32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " done"},     32'(done),     32'd0);
    chk({tag, " err"},      32'(err),      32'd0);
    chk({tag, " cpu_rst"},  32'(cpu_rst),  32'd1);
  endtask

  initial begin
    good_frm = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h20, 8'h09, 8'h00, 8'h0A, 8'h0E};
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk_reset_outs("reset");
    rst = 1'b1;
    tick();

    // Good load, N=2
    base = wr_n;
    pulse_start();
    chk("t1 busy", 32'(busy), 32'd1);
    chk("t1 in_ready", 32'(in_ready), 32'd1);
    load_good(8'h0E, 1'b0, -1);
    chk("t1 done", 32'(done), 32'd1);
    chk("t1 err", 32'(err), 32'd0);
    chk("t1 cpu_rst", 32'(cpu_rst), 32'd0);
    chk("t1 in_ready", 32'(in_ready), 32'd0);
    chk_two_writes("t1");
    tick(); tick();
    chk("t1 done hold", 32'(done), 32'd1);
    chk("t1 wdata hold", im_wdata, 32'h2009_000A);
    chk("t1 addr hold", 32'(im_addr), 32'd1);

    // Back-to-back load, N=1
    base = wr_n;
    pulse_start();
    chk("b2b done clr", 32'(done), 32'd0);
    chk("b2b cpu_rst", 32'(cpu_rst), 32'd1);
    send(8'h00); send(8'h01); send(8'h24); send(8'h0A); send(8'h00); send(8'h01);
    send(8'h2F);
    chk("b2b done", 32'(done), 32'd1);
    chk("b2b nwr", 32'(wr_n - base), 32'd1);
    chk("b2b a0", wr_addr[base], 32'd0);
    chk("b2b d0", wr_data[base], 32'h240A_0001);

    // Bad checksum
    base = wr_n;
    pulse_start();
    load_good(8'h0F, 1'b0, -1);
    chk("bad err", 32'(err), 32'd1);
    chk("bad done", 32'(done), 32'd0);
    chk("bad cpu_rst", 32'(cpu_rst), 32'd1);
    chk_two_writes("bad");

    // N=0
    base = wr_n;
    pulse_start();
    send(8'h00); send(8'h00);
    chk("n0 err", 32'(err), 32'd1);
    chk("n0 in_ready", 32'(in_ready), 32'd0);
    chk("n0 busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("n0 nwr", 32'(wr_n - base), 32'd0);

    // N=17 exceeds depth 16
    pulse_start();
    chk("n17 err clr", 32'(err), 32'd0);
    send(8'h00); send(8'h11);
    chk("n17 err", 32'(err), 32'd1);
    chk("n17 busy", 32'(busy), 32'd0);

    // N=16 is exactly the depth and is accepted
    pulse_start();
    send(8'h00); send(8'h10);
    chk("n16 err", 32'(err), 32'd0);
    chk("n16 in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0; #2; rst = 1'b1;
    chk("n16 rst busy", 32'(busy), 32'd0);
    tick();

    // Stalled stream with a start pulse during DATA
    base = wr_n;
    pulse_start();
    load_good(8'h0E, 1'b1, 5);
    chk("stall done", 32'(done), 32'd1);
    chk("stall err", 32'(err), 32'd0);
    chk("stall cpu_rst", 32'(cpu_rst), 32'd0);
    chk_two_writes("stall");

    // Async reset mid-DATA, during the word-0 write pulse
    pulse_start();
    send(8'h00); send(8'h02); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    chk("ar we pre", 32'(im_we), 32'd1);
    chk("ar wdata pre", im_wdata, 32'h2008_0005);
    #1 rst = 1'b0;
    #1 chk_reset_outs("arst");
    #1 rst = 1'b1;
    tick();
    base = wr_n;
    pulse_start();
    load_good(8'h0E, 1'b0, -1);
    chk("reload done", 32'(done), 32'd1);
    chk("reload cpu_rst", 32'(cpu_rst), 32'd0);
    chk_two_writes("reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
